// File: rtl/burst_scheduler_if.sv
// Request / command / burst_len FIFO handshake bundle for burst_scheduler.
// master = the scheduler side, slave = the FIFO/environment side.
interface burst_scheduler_if #(
  parameter int AddrWidth     = 64,
  parameter int LenWidth      = 32,
  parameter int BurstLenWidth = 8
);
  // request FIFO read side
  logic [AddrWidth-1:0]     req_addr_dout;
  logic [LenWidth-1:0]      req_len_dout;
  logic                     req_empty_n;
  logic                     req_read;
  // AW/AR command FIFO write side
  logic [AddrWidth-1:0]     cmd_addr_din;
  logic [BurstLenWidth-1:0] cmd_len_din;
  logic                     cmd_full_n;
  logic                     cmd_write;
  // burst_len FIFO write side (feeds the last-flag generator)
  logic [BurstLenWidth-1:0] burst_len_din;
  logic                     burst_len_full_n;
  logic                     burst_len_write;

  modport master (
    input  req_addr_dout, req_len_dout, req_empty_n, cmd_full_n, burst_len_full_n,
    output req_read, cmd_addr_din, cmd_len_din, cmd_write, burst_len_din, burst_len_write
  );

  modport slave (
    output req_addr_dout, req_len_dout, req_empty_n, cmd_full_n, burst_len_full_n,
    input  req_read, cmd_addr_din, cmd_len_din, cmd_write, burst_len_din, burst_len_write
  );
endinterface

// File: rtl/burst_scheduler.sv
// Splits (addr, beats) requests into AXI-legal bursts: each burst is at most
// MaxBurstLen beats and never crosses a Boundary-byte page. Every burst is
// pushed to the command FIFO and the burst_len FIFO in the same cycle.
module burst_scheduler #(
  parameter int AddrWidth      = 64,
  parameter int LenWidth       = 32,
  parameter int BurstLenWidth  = 8,
  parameter int DataWidthBytes = 4,
  parameter int MaxBurstLen    = 256,
  parameter int Boundary       = 4096
) (
  input  logic               clk,
  input  logic               rst,
  burst_scheduler_if.master  bus
);
  localparam int OffBits = $clog2(DataWidthBytes);
  localparam int BndBits = $clog2(Boundary);
  localparam int CalcW   = LenWidth + 1;

  localparam logic [BndBits:0]     BndFull   = (BndBits+1)'(Boundary);
  localparam logic [CalcW-1:0]     MaxBeats  = CalcW'(MaxBurstLen);
  localparam logic [AddrWidth-1:0] AlignMask = ~(AddrWidth'(DataWidthBytes - 1));

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t               state;
  logic [AddrWidth-1:0] addr;
  logic [LenWidth-1:0]  remaining;

  logic [BndBits:0]     bnd_bytes;
  logic [CalcW-1:0]     to_bnd;
  logic [CalcW-1:0]     beats;
  logic                 fire;

  // Size of the next burst: min(remaining, MaxBurstLen, beats left in page),
  // all at LenWidth+1 bits so nothing truncates before the min.
  always_comb begin
    bnd_bytes = BndFull - {1'b0, addr[BndBits-1:0]};
    to_bnd    = CalcW'(bnd_bytes >> OffBits);
    beats     = {1'b0, remaining};
    if (beats > MaxBeats) beats = MaxBeats;
    if (beats > to_bnd)   beats = to_bnd;
  end

  // Both FIFOs must have room; they are never written independently.
  // Strobes are held low during the reset cycle itself.
  assign fire                = (state == SPLIT) && bus.cmd_full_n && bus.burst_len_full_n && !rst;
  assign bus.req_read        = (state == IDLE) && bus.req_empty_n && !rst;
  assign bus.cmd_write       = fire;
  assign bus.burst_len_write = fire;
  assign bus.cmd_addr_din    = addr;
  assign bus.cmd_len_din     = BurstLenWidth'(beats - 1'b1);
  assign bus.burst_len_din   = BurstLenWidth'(beats - 1'b1);

  // Request pop in IDLE, one burst per cycle in SPLIT; a stall freezes all state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_empty_n) begin
            addr      <= bus.req_addr_dout & AlignMask;
            remaining <= bus.req_len_dout;
            // zero-length requests are swallowed without any output
            if (bus.req_len_dout != '0) state <= SPLIT;
          end
        end
        SPLIT: begin
          if (fire) begin
            addr      <= addr + (AddrWidth'(beats) << OffBits);
            remaining <= remaining - beats[LenWidth-1:0];
            if ({1'b0, remaining} == beats) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
